// File: rtl/riscv_pipe_pkg.sv
// Shared types and defaults for the RISC-V pipeline front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pipe_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_BUBBLE_INSTR = 32'h0000_0000;

    // IDLE: nothing outstanding, WAIT: live request outstanding,
    // KILL: outstanding request whose response is to be discarded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {instr, pc} pairs; head is combinational from entry 0.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: pop is gated by the consumer; push into a full FIFO without a pop is ignored; clear wins.
// Ports: clk, rst (async active-low), push/push_entry, pop, clear, count (0..2), head.
import riscv_pipe_pkg::*;

module fetch_buffer (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         clear,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entry0;
    fetch_entry_t entry1;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok  = pop & (count != 2'd0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign push_ok = push & ((count != 2'd2) | pop_ok);
    assign head    = entry0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= push_entry;
                    end else begin
                        entry1 <= push_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; shift and refill behind the new head.
                    if (count == 2'd1) begin
                        entry0 <= push_entry;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem request FSM, 2-deep instruction buffer.
// Latency: grant to INSTR_IF = memory response latency + 1 cycle; 1 instr/cycle with 1-cycle memory.
// Backpressure: stall_IF_ID holds the head; fetch stops once buffered + outstanding reaches 2.
// Ports: clk, rst (async active-low); stall_IF_ID, redirect_valid/redirect_pc from the pipeline;
//        imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata to instruction memory;
//        INSTR_IF/PC_IF to the IF/ID register (bubble / 0 when empty).
import riscv_pipe_pkg::*;

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter logic [31:0] BUBBLE_INSTR = DEFAULT_BUBBLE_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_IF_ID,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] INSTR_IF,
    output logic [31:0] PC_IF
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc;

    logic [1:0]   buf_count;
    fetch_entry_t buf_head;
    fetch_entry_t push_entry;
    logic         buf_nonempty;
    logic         consume;
    logic         arrive;
    logic         grant;
    logic [2:0]   occ_next;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign buf_nonempty = (buf_count != 2'd0);
    assign consume      = buf_nonempty & ~stall_IF_ID & ~redirect_valid;
    // Responses in KILL (stale) or IDLE (protocol violation) never reach the buffer.
    assign arrive       = imem_rvalid & (state == WAIT);
    assign occ_next     = {1'b0, buf_count} - {2'b00, consume} + {2'b00, arrive};

    // A new request may go out when the previous one is finished (IDLE) or finishing
    // this cycle (rvalid), and only if the buffer can still absorb its response.
    // Deliberately independent of imem_gnt.
    assign imem_req  = ~redirect_valid & ((state == IDLE) | imem_rvalid) & (occ_next <= 3'd1);
    assign imem_addr = pc_q;
    assign grant     = imem_req & imem_gnt;

    assign push_entry = '{instr: imem_rdata, pc: req_pc};

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (arrive),
        .push_entry (push_entry),
        .pop        (consume),
        .clear      (redirect_valid),
        .count      (buf_count),
        .head       (buf_head)
    );

    assign INSTR_IF = buf_nonempty ? buf_head.instr : BUBBLE_INSTR;
    assign PC_IF    = buf_nonempty ? buf_head.pc    : 32'h0000_0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pc_q   <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= {redirect_pc[31:2], 2'b00};
            // Any request still in flight (live or already killed) must have its
            // response swallowed; one returning right now is simply dropped.
            if ((state != IDLE) && !imem_rvalid) begin
                state <= KILL;
            end else begin
                state <= IDLE;
            end
        end else if (grant) begin
            req_pc <= pc_q;
            pc_q   <= pc_q + 32'd4;
            state  <= WAIT;
        end else if (imem_rvalid) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] BUBBLE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_IF_ID = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt_ok = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] INSTR_IF;
    logic [31:0] PC_IF;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int budget = 0;
    int lat = 1;
    logic inject_late = 1'b0;

    // Scoreboard and memory model state
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];
    int          mem_due_q[$];
    logic [31:0] mem_addr_q[$];

    int bb_chk = 0;
    int rel_cyc = 0;
    int last_cons = -1;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall_IF_ID    (stall_IF_ID),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (gnt_ok),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .INSTR_IF       (INSTR_IF),
        .PC_IF          (PC_IF)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
        exp_instr_q.push_back(instr);
        exp_pc_q.push_back(pc);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            #4;
            if (exp_pc_q.size() == 0) break;
        end
        check({"drain_", name}, exp_pc_q.size(), 0);
        exp_instr_q.delete();
        exp_pc_q.delete();
    endtask

    // Memory model: drives response at negedge+1, grant at negedge+1, records handshake at +2.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                mem_due_q.delete();
                mem_addr_q.delete();
                imem_rvalid = inject_late;
                imem_rdata  = 32'hDEAD_BEEF;
            end else if (mem_due_q.size() > 0 && mem_due_q[0] == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_addr_q[0] ^ 32'hA5A5_0000;
                void'(mem_due_q.pop_front());
                void'(mem_addr_q.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
            gnt_ok = rst && (budget > 0);
            #1;
            if (rst && imem_req && gnt_ok) begin
                mem_due_q.push_back(cyc + lat);
                mem_addr_q.push_back(imem_addr);
                budget--;
            end
        end
    end

    // Monitor: every cycle the head is consumed, compare it with the scoreboard.
    initial begin
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        forever begin
            @(negedge clk);
            #3;
            if (rst && INSTR_IF != BUBBLE && !stall_IF_ID && !redirect_valid) begin
                if (exp_pc_q.size() == 0) begin
                    check("sb_unexpected_instr", INSTR_IF, BUBBLE);
                end else begin
                    e_instr = exp_instr_q.pop_front();
                    e_pc    = exp_pc_q.pop_front();
                    check("sb_instr", INSTR_IF, e_instr);
                    check("sb_pc", PC_IF, e_pc);
                end
                if (bb_chk != 0) begin
                    if (last_cons < 0) check("first_latency", cyc - rel_cyc, 2);
                    else               check("no_bubble", cyc - last_cons, 1);
                    last_cons = cyc;
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #3;
        check("rst_instr", INSTR_IF, BUBBLE);
        check("rst_pc", PC_IF, 32'h0);
        check("rst_req", imem_req, 1);
        check("rst_addr", imem_addr, 32'h0);

        // Streaming with 1-cycle memory
        push_exp(32'hA5A5_0000, 32'h00); push_exp(32'hA5A5_0004, 32'h04);
        push_exp(32'hA5A5_0008, 32'h08); push_exp(32'hA5A5_000C, 32'h0C);
        push_exp(32'hA5A5_0010, 32'h10); push_exp(32'hA5A5_0014, 32'h14);
        @(negedge clk);
        budget = 6; lat = 1; bb_chk = 1; rel_cyc = cyc;
        rst = 1'b1;
        wait_drain("stream", 40);
        bb_chk = 0;

        // Stall held 5 cycles mid-stream
        push_exp(32'hA5A5_0018, 32'h18); push_exp(32'hA5A5_001C, 32'h1C);
        push_exp(32'hA5A5_0020, 32'h20); push_exp(32'hA5A5_0024, 32'h24);
        push_exp(32'hA5A5_0028, 32'h28); push_exp(32'hA5A5_002C, 32'h2C);
        push_exp(32'hA5A5_0030, 32'h30); push_exp(32'hA5A5_0034, 32'h34);
        @(negedge clk);
        budget = 8;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            stall_IF_ID = 1'b1;
            #3;
            check("stall_pc", PC_IF, 32'h1C);
            check("stall_instr", INSTR_IF, 32'hA5A5_001C);
        end
        check("stall_full_no_req", imem_req, 0);
        @(negedge clk);
        stall_IF_ID = 1'b0;
        wait_drain("stall", 40);

        // Redirect while a 3-cycle request is outstanding
        push_exp(32'hA5A5_0200, 32'h200); push_exp(32'hA5A5_0204, 32'h204);
        @(negedge clk);
        budget = 1; lat = 3;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; budget = 2;
        #3;
        check("redir_no_req", imem_req, 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("kill_wait_no_req", imem_req, 0);
        @(negedge clk);
        #3;
        check("kill_req", imem_req, 1);
        check("kill_addr", imem_addr, 32'h0000_0200);
        wait_drain("kill", 40);

        // Redirect together with rvalid and stall
        push_exp(32'hA5A5_0100, 32'h100);
        @(negedge clk);
        budget = 3; lat = 1; stall_IF_ID = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        #3;
        check("redir_rv_no_req", imem_req, 0);
        @(negedge clk);
        redirect_valid = 1'b0; stall_IF_ID = 1'b0;
        #3;
        check("clr_instr", INSTR_IF, BUBBLE);
        check("clr_pc", PC_IF, 32'h0);
        check("clr_req", imem_req, 1);
        check("clr_addr", imem_addr, 32'h0000_0100);
        wait_drain("redir_stall", 40);

        // Address wrap at 0xFFFF_FFFC
        push_exp(32'h5A5A_FFF8, 32'hFFFF_FFF8); push_exp(32'h5A5A_FFFC, 32'hFFFF_FFFC);
        push_exp(32'hA5A5_0000, 32'h0000_0000); push_exp(32'hA5A5_0004, 32'h0000_0004);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB; budget = 4; lat = 1;
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("wrap_start_addr", imem_addr, 32'hFFFF_FFF8);
        repeat (2) @(negedge clk);
        #3;
        check("wrap_addr", imem_addr, 32'h0000_0000);
        wait_drain("wrap", 40);

        // Reset with an instruction buffered and a request outstanding
        @(negedge clk);
        budget = 2; lat = 3; stall_IF_ID = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        check("pre_rst_pc", PC_IF, 32'h8);
        @(negedge clk);
        rst = 1'b0; budget = 0;
        #3;
        check("mid_rst_instr", INSTR_IF, BUBBLE);
        check("mid_rst_pc", PC_IF, 32'h0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_req", imem_req, 1);
        @(negedge clk);
        inject_late = 1'b1;
        #3;
        check("late_rv_instr", INSTR_IF, BUBBLE);
        check("late_rv_pc", PC_IF, 32'h0);
        push_exp(32'hA5A5_0000, 32'h0); push_exp(32'hA5A5_0004, 32'h4);
        @(negedge clk);
        inject_late = 1'b0; rst = 1'b1; stall_IF_ID = 1'b0; budget = 2; lat = 1;
        wait_drain("after_rst", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
